// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the reduced RISC-V core: sequences fetch, decode,
// execute, memory and writeback over a shared req/ready memory port.
module multicycle_control #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             EQ,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCsrc,
    output logic             RegWrite,
    output logic [2:0]       ALUctrl,
    output logic             ALUsrc,
    output logic [1:0]       ImmSrc,
    output logic             ResultSrc,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);

    localparam int                WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam bit                TIMEOUT_EN = (MAX_WAIT > 0);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [6:0]        opcode_q;
    logic [2:0]        funct3_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              set_illegal;
    logic              set_timeout;
    logic              wait_expired;
    logic              is_opimm;
    logic              is_branch;
    logic              is_lw;
    logic              is_sw;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    assign is_opimm  = (opcode_q == OP_IMM);
    assign is_branch = (opcode_q == OP_BRANCH) && (funct3_q == 3'b000 || funct3_q == 3'b001);
    assign is_lw     = (opcode_q == OP_LOAD)  && (funct3_q == 3'b010);
    assign is_sw     = (opcode_q == OP_STORE) && (funct3_q == 3'b010);

    // A ready arriving on the limit cycle wins, so expiry requires ready low.
    assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT) && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= '0;
            funct3_q <= '0;
        end else if (IRWrite) begin
            opcode_q <= instr[6:0];
            funct3_q <= instr[14:12];
        end
    end

    // Counter is zero whenever a request starts because every non-waiting cycle clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
            timeout <= 1'b0;
            instret <= '0;
        end else begin
            illegal <= illegal | set_illegal;
            timeout <= timeout | set_timeout;
            if (PCWrite) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCsrc       = 1'b0;
        RegWrite    = 1'b0;
        ALUctrl     = 3'b000;
        ALUsrc      = 1'b0;
        ImmSrc      = 2'b00;
        ResultSrc   = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    next_state = S_DECODE;
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_DECODE: begin
                if (is_opimm || is_branch || is_lw || is_sw) begin
                    next_state = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_EXEC: begin
                if (is_opimm) begin
                    ALUctrl    = funct3_q;
                    ALUsrc     = 1'b1;
                    next_state = S_WB;
                end else if (is_branch) begin
                    ImmSrc     = 2'b10;
                    PCWrite    = 1'b1;
                    PCsrc      = funct3_q[0] ? !EQ : EQ;
                    next_state = S_FETCH;
                end else begin
                    ALUsrc     = 1'b1;
                    ImmSrc     = {1'b0, is_sw};
                    next_state = S_MEM;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                ALUsrc  = 1'b1;
                ImmSrc  = {1'b0, is_sw};
                if (mem_ready) begin
                    if (is_sw) begin
                        PCWrite    = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                ResultSrc  = is_lw;
                PCWrite    = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // Reset is asynchronous, so strobes must vanish the moment it rises.
        if (rst) begin
            next_state  = S_FETCH;
            set_illegal = 1'b0;
            set_timeout = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCsrc       = 1'b0;
            RegWrite    = 1'b0;
            ALUctrl     = 3'b000;
            ALUsrc      = 1'b0;
            ImmSrc      = 2'b00;
            ResultSrc   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: expands each instruction into its expected
// per-cycle output trace from the instruction-level rules, then replays it.
module tb_multicycle_control;

    localparam int MW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = '0;
    logic          EQ = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite;
    logic [2:0]    ALUctrl;
    logic          ALUsrc;
    logic [1:0]    ImmSrc;
    logic          ResultSrc, illegal, timeout;
    logic [CW-1:0] instret;

    multicycle_control #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
        .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .illegal(illegal), .timeout(timeout),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst;
        logic [31:0]   instr;
        logic          eq;
        logic          ready;
        logic          memReq, memWe, irWrite, pcWrite, pcSrc, regWrite;
        logic [2:0]    aluCtrl;
        logic          aluSrc;
        logic [1:0]    immSrc;
        logic          resultSrc, illegal, timeout;
        logic [CW-1:0] instret;
    } vec_t;

    vec_t          vecs[$];
    logic [CW-1:0] mCount = '0;
    logic          mIllegal = 1'b0;
    logic          mTimeout = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // Inputs that should not matter in a cycle are randomised.
    function automatic vec_t blank(input string name);
        vec_t v;
        v.name = name;          v.rst = 1'b0;
        v.instr = $urandom;     v.eq = 1'($urandom);    v.ready = 1'($urandom);
        v.memReq = 1'b0;        v.memWe = 1'b0;         v.irWrite = 1'b0;
        v.pcWrite = 1'b0;       v.pcSrc = 1'b0;         v.regWrite = 1'b0;
        v.aluCtrl = 3'b000;     v.aluSrc = 1'b0;        v.immSrc = 2'b00;
        v.resultSrc = 1'b0;     v.illegal = mIllegal;   v.timeout = mTimeout;
        v.instret = mCount;
        return v;
    endfunction

    function automatic vec_t memVec(input string name, input bit isSw, input logic ready);
        vec_t v;
        v = blank(name);
        v.ready = ready;
        v.memReq = 1'b1;
        v.memWe = isSw;
        v.aluSrc = 1'b1;
        v.immSrc = {1'b0, isSw};
        return v;
    endfunction

    task automatic pushVec(input vec_t v);
        if (v.rst) begin
            mCount = '0;
            mIllegal = 1'b0;
            mTimeout = 1'b0;
            v.illegal = 1'b0;
            v.timeout = 1'b0;
        end
        v.instret = mCount;
        vecs.push_back(v);
        if (v.pcWrite) mCount = mCount + 1'b1;
    endtask

    task automatic addReset(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = blank("reset");
            v.rst = 1'b1;
            pushVec(v);
        end
    endtask

    task automatic addTrap(input string name, input int n);
        for (int i = 0; i < n; i++) pushVec(blank(name));
    endtask

    // fWait/mWait: ready-low cycles before ready in each request; > MW means timeout.
    task automatic addInstr(input logic [31:0] ins, input logic eq, input int fWait,
                            input int mWait, input int trapCycles, input bit abortMem);
        vec_t       v;
        logic [6:0] op;
        logic [2:0] f3;
        bit         isOpImm, isBr, isLw, isSw;
        op = ins[6:0];
        f3 = ins[14:12];
        isOpImm = (op == 7'h13);
        isBr    = (op == 7'h63) && (f3 == 3'd0 || f3 == 3'd1);
        isLw    = (op == 7'h03) && (f3 == 3'd2);
        isSw    = (op == 7'h23) && (f3 == 3'd2);

        for (int i = 0; i < fWait && i <= MW; i++) begin
            v = blank("fetch_wait");
            v.ready = 1'b0;
            v.memReq = 1'b1;
            pushVec(v);
        end
        if (fWait > MW) begin
            mTimeout = 1'b1;
            addTrap("trap_timeout", trapCycles);
            return;
        end
        v = blank("fetch");
        v.ready = 1'b1;
        v.instr = ins;
        v.memReq = 1'b1;
        v.irWrite = 1'b1;
        pushVec(v);
        pushVec(blank("decode"));

        if (!(isOpImm || isBr || isLw || isSw)) begin
            mIllegal = 1'b1;
            addTrap("trap_illegal", trapCycles);
            return;
        end

        v = blank("exec");
        if (isOpImm) begin
            v.aluCtrl = f3;
            v.aluSrc = 1'b1;
            pushVec(v);
            v = blank("wb_opimm");
            v.regWrite = 1'b1;
            v.pcWrite = 1'b1;
            pushVec(v);
        end else if (isBr) begin
            v.eq = eq;
            v.immSrc = 2'b10;
            v.pcWrite = 1'b1;
            v.pcSrc = f3[0] ? !eq : eq;
            pushVec(v);
        end else begin
            v.aluSrc = 1'b1;
            v.immSrc = {1'b0, isSw};
            pushVec(v);
            for (int i = 0; i < mWait && i <= MW; i++) pushVec(memVec("mem_wait", isSw, 1'b0));
            if (abortMem) return;
            if (mWait > MW) begin
                mTimeout = 1'b1;
                addTrap("trap_timeout", trapCycles);
                return;
            end
            v = memVec("mem_done", isSw, 1'b1);
            v.pcWrite = isSw;
            pushVec(v);
            if (isLw) begin
                v = blank("wb_lw");
                v.regWrite = 1'b1;
                v.resultSrc = 1'b1;
                v.pcWrite = 1'b1;
                pushVec(v);
            end
        end
    endtask

    function automatic logic [18:0] packExp(input vec_t v);
        return {v.memReq, v.memWe, v.irWrite, v.pcWrite, v.pcSrc, v.regWrite,
                v.aluCtrl, v.aluSrc, v.immSrc, v.resultSrc, v.illegal, v.timeout, v.instret};
    endfunction

    task automatic checkOutput(input vec_t v, input int idx);
        logic [18:0] act, exp;
        act = {mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite,
               ALUctrl, ALUsrc, ImmSrc, ResultSrc, illegal, timeout, instret};
        exp = packExp(v);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vec %0d): got %05h expected %05h", v.name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            instr = vecs[i].instr;
            EQ = vecs[i].eq;
            mem_ready = vecs[i].ready;
            #2;
            checkOutput(vecs[i], i);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic addRandom(input int n);
        logic [31:0] ins;
        int          k;
        for (int i = 0; i < n; i++) begin
            ins = $urandom;
            k = $urandom_range(0, 4);
            case (k)
                0: ins[6:0] = 7'h13;
                1: begin ins[6:0] = 7'h63; ins[14:12] = 3'd0; end
                2: begin ins[6:0] = 7'h63; ins[14:12] = 3'd1; end
                3: begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
                default: begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
            endcase
            addInstr(ins, 1'($urandom), $urandom_range(0, MW), $urandom_range(0, MW), 0, 1'b0);
        end
    endtask

    initial begin
        $display("[TB] building vector table");
        addReset(2);
        addInstr(32'h00500093, 1'b0, 0, 0, 0, 1'b0);
        addInstr(32'h00208463, 1'b1, 0, 0, 0, 1'b0);
        addInstr(32'h00208463, 1'b0, 0, 0, 0, 1'b0);
        addInstr(32'h00209463, 1'b0, 0, 0, 0, 1'b0);
        addInstr(32'h0000A103, 1'b0, 0, 3, 0, 1'b0);
        addInstr(32'h0020A023, 1'b0, 0, 0, 0, 1'b0);
        addInstr(32'h0070E093, 1'b0, 1, 0, 0, 1'b0);
        addInstr(32'h0000A103, 1'b0, MW, MW, 0, 1'b0);
        addInstr(32'h00209463, 1'b1, 2, 0, 0, 1'b0);
        addRandom(60);

        addReset(1);
        addInstr(32'h0000A103, 1'b0, 1, 2, 0, 1'b1);
        addReset(1);
        addInstr(32'h00500093, 1'b0, 0, 0, 0, 1'b0);

        addInstr(32'h0000007F, 1'b0, 0, 0, 20, 1'b0);
        addReset(1);
        addInstr(32'h00500093, 1'b0, 0, 0, 0, 1'b0);
        addInstr(32'h0020A463, 1'b0, 0, 0, 3, 1'b0);
        addReset(1);
        addInstr(32'h00009103, 1'b0, 0, 0, 3, 1'b0);
        addReset(1);

        addInstr(32'h00500093, 1'b0, MW + 1, 0, 5, 1'b0);
        addReset(1);
        addInstr(32'h0020A023, 1'b0, 0, MW + 1, 5, 1'b0);
        addReset(1);
        addInstr(32'h0020A023, 1'b0, 0, MW, 0, 1'b0);

        $display("[TB] applying %0d vectors", vecs.size());
        @(posedge clk);
        #1;
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
